ib_vc: RTL and testbench

Parametrised next-generation switch input buffer with NUM_VC virtual channels, one FIFO per VC, and wormhole packet forwarding. It sits between an input link and the crossbar/output arbiter. The block decodes the route from the head flit, issues a one-hot request, and streams the whole packet once acknowledged. It returns per-VC credits upstream and flags overflow and malformed-packet errors.

---
 rtl/sw_pkg.sv | 37 +++
 rtl/ib_fifo.sv | 53 +++++
 rtl/ib_vc.sv | 174 +++++++++++++++++
 tb/tb_ib_vc.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sw_pkg.sv
// Shared types and field helpers for the switch input buffer.
package sw_pkg;

  typedef enum logic [1:0] {
    BODY     = 2'b00,
    HEAD     = 2'b01,
    TAIL     = 2'b10,
    HEADTAIL = 2'b11
  } flit_type_e;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    XFER,
    DROP
  } state_e;

  localparam int TYPE_W = 2;

  function automatic int vc_width(input int num_vc);
    return (num_vc > 1) ? $clog2(num_vc) : 1;
  endfunction

  function automatic int flit_width(input int data_w, input int num_vc);
    return 1 + vc_width(num_vc) + TYPE_W + data_w;
  endfunction

  // Head and headtail share bit 0, tail and headtail share bit 1.
  function automatic logic is_head(input logic [TYPE_W-1:0] t);
    return t[0];
  endfunction

  function automatic logic is_tail(input logic [TYPE_W-1:0] t);
    return t[1];
  endfunction

endpackage

// File: rtl/ib_fifo.sv
// Per-VC flit FIFO; full is occupancy-only, so a same-cycle pop never frees room for a push.
module ib_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 36
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] front
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign front   = mem[rd_ptr];

  // Storage array, written only on accepted pushes.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data;
  end

  // Pointers and occupancy; power-of-two depth lets the pointers wrap by overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ib_vc.sv
// Input buffer with per-VC FIFOs, round-robin packet selection and wormhole forwarding.
module ib_vc
  import sw_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 4,
  parameter int NUM_VC   = 2,
  parameter int NUM_PORT = 5,
  parameter int DST_W    = 3,
  localparam int VC_W    = vc_width(NUM_VC),
  localparam int FLIT_W  = flit_width(DATA_W, NUM_VC)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [FLIT_W-1:0]   pkti,
  output logic [FLIT_W-1:0]   pkto,
  output logic [NUM_PORT-1:0] req,
  input  logic                ack,
  output logic [NUM_VC-1:0]   full,
  output logic [NUM_VC-1:0]   credit,
  output logic                err_ovf,
  output logic                err_pkt
);

  localparam int TYPE_LSB = DATA_W;
  localparam int VC_LSB   = DATA_W + TYPE_W;

  state_e              state, state_nxt;
  logic [VC_W-1:0]     sel_vc, sel_nxt;
  logic [VC_W-1:0]     rr_ptr, rr_nxt;
  logic [NUM_PORT-1:0] req_nxt;
  logic                err_pkt_nxt;
  logic                ovf_nxt;
  logic [NUM_VC-1:0]   push;
  logic [NUM_VC-1:0]   pop;
  logic [NUM_VC-1:0]   empty;
  logic [FLIT_W-1:0]   front [NUM_VC];

  logic                in_valid;
  logic [VC_W-1:0]     in_vc;
  logic                found;
  logic [VC_W-1:0]     pick;
  logic [VC_W-1:0]     cand;
  logic [TYPE_W-1:0]   pick_type;
  logic [DST_W-1:0]    pick_dst;
  logic                dst_ok;
  logic [FLIT_W-1:0]   sel_flit;
  logic [TYPE_W-1:0]   sel_type;
  logic                sel_empty;

  assign in_valid  = pkti[FLIT_W-1];
  assign in_vc     = pkti[VC_LSB +: VC_W];
  assign pick_type = front[pick][TYPE_LSB +: TYPE_W];
  assign pick_dst  = front[pick][DST_W-1:0];
  assign dst_ok    = (32'(pick_dst) < 32'(NUM_PORT));
  assign sel_flit  = front[sel_vc];
  assign sel_type  = sel_flit[TYPE_LSB +: TYPE_W];
  assign sel_empty = empty[sel_vc];

  for (genvar g = 0; g < NUM_VC; g++) begin : g_fifo
    ib_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (FLIT_W)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[g]),
      .data  (pkti),
      .pop   (pop[g]),
      .full  (full[g]),
      .empty (empty[g]),
      .front (front[g])
    );
  end

  // Steer an incoming flit to its VC, or flag it as an overflow when that VC is full.
  always_comb begin
    push    = '0;
    ovf_nxt = 1'b0;
    for (int v = 0; v < NUM_VC; v++) begin
      if (in_valid && (in_vc == VC_W'(v))) begin
        if (full[v]) ovf_nxt = 1'b1;
        else         push[v] = 1'b1;
      end
    end
  end

  // Round-robin scan for the first non-empty VC, starting just after the last one served.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int i = 1; i <= NUM_VC; i++) begin
      cand = VC_W'((int'(rr_ptr) + i) % NUM_VC);
      if (!found && !empty[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Packet FSM: route decode in IDLE, streaming in REQ/XFER, discard of malformed packets in DROP.
  always_comb begin
    state_nxt   = state;
    sel_nxt     = sel_vc;
    rr_nxt      = rr_ptr;
    req_nxt     = req;
    err_pkt_nxt = 1'b0;
    pop         = '0;
    pkto        = '0;
    case (state)
      IDLE: begin
        if (found) begin
          sel_nxt = pick;
          if (is_head(pick_type) && dst_ok) begin
            req_nxt   = NUM_PORT'(1) << pick_dst;
            state_nxt = REQ;
          end else begin
            err_pkt_nxt = 1'b1;
            state_nxt   = DROP;
          end
        end
      end
      REQ, XFER: begin
        if (!sel_empty) begin
          pkto           = sel_flit;
          pkto[FLIT_W-1] = 1'b1;
          if (ack) begin
            pop[sel_vc] = 1'b1;
            if (is_tail(sel_type)) begin
              req_nxt   = '0;
              rr_nxt    = sel_vc;
              state_nxt = IDLE;
            end else if (state == REQ) begin
              state_nxt = XFER;
            end
          end
        end
      end
      DROP: begin
        if (!sel_empty) begin
          pop[sel_vc] = 1'b1;
          if (is_tail(sel_type)) begin
            rr_nxt    = sel_vc;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, selection, request and pulse registers; reset drops req immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      sel_vc  <= '0;
      rr_ptr  <= '0;
      req     <= '0;
      credit  <= '0;
      err_ovf <= 1'b0;
      err_pkt <= 1'b0;
    end else begin
      state   <= state_nxt;
      sel_vc  <= sel_nxt;
      rr_ptr  <= rr_nxt;
      req     <= req_nxt;
      credit  <= pop;
      err_ovf <= ovf_nxt;
      err_pkt <= err_pkt_nxt;
    end
  end

endmodule

// File: tb/tb_ib_vc.sv
// Directed testbench for ib_vc with hand-computed expected values.
module tb_ib_vc;
  import sw_pkg::*;

  localparam int FLIT_W = 36;

  logic              clk = 1'b0;
  logic              rst;
  logic [FLIT_W-1:0] pkti;
  logic [FLIT_W-1:0] pkto;
  logic [4:0]        req;
  logic              ack;
  logic [1:0]        full;
  logic [1:0]        credit;
  logic              err_ovf;
  logic              err_pkt;

  int checks = 0;
  int errors = 0;

  ib_vc #(
    .DATA_W   (32),
    .DEPTH    (4),
    .NUM_VC   (2),
    .NUM_PORT (5),
    .DST_W    (3)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .pkti    (pkti),
    .pkto    (pkto),
    .req     (req),
    .ack     (ack),
    .full    (full),
    .credit  (credit),
    .err_ovf (err_ovf),
    .err_pkt (err_pkt)
  );

  always #5 clk = ~clk;

  function automatic logic [FLIT_W-1:0] mk(input logic vc, input logic [1:0] t, input logic [31:0] p);
    return {1'b1, vc, t, p};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [FLIT_W-1:0] f);
    pkti = f;
    step();
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst  = 1'b1;
    pkti = '0;
    ack  = 1'b0;
    step();
    step();
    checkOutput("rst req", req, 0);
    checkOutput("rst pkto", pkto, 0);
    checkOutput("rst full", full, 0);
    checkOutput("rst credit", credit, 0);
    checkOutput("rst err_ovf", err_ovf, 0);
    checkOutput("rst err_pkt", err_pkt, 0);
    rst = 1'b0;
    step();

    $display("[TB] single packet on VC0");
    ack = 1'b1;
    checkOutput("t1 req idle", req, 0);
    applyStimulus(mk(0, HEAD, 32'h2));
    checkOutput("t1 req t+1", req, 0);
    applyStimulus(mk(0, BODY, 32'hB0D1));
    checkOutput("t1 req t+2", req, 5'b00100);
    checkOutput("t1 head out", pkto, mk(0, HEAD, 32'h2));
    applyStimulus(mk(0, TAIL, 32'h7A11));
    pkti = '0;
    checkOutput("t1 body out", pkto, mk(0, BODY, 32'hB0D1));
    checkOutput("t1 credit a", credit, 2'b01);
    step();
    checkOutput("t1 tail out", pkto, mk(0, TAIL, 32'h7A11));
    checkOutput("t1 credit b", credit, 2'b01);
    checkOutput("t1 req held", req, 5'b00100);
    step();
    checkOutput("t1 req done", req, 0);
    checkOutput("t1 pkto idle", pkto, 0);
    checkOutput("t1 credit c", credit, 2'b01);
    step();
    checkOutput("t1 credit end", credit, 0);

    $display("[TB] round-robin between VCs");
    ack = 1'b0;
    applyStimulus(mk(0, HEADTAIL, 32'h10));
    applyStimulus(mk(0, HEAD, 32'h1));
    applyStimulus(mk(0, TAIL, 32'h2A));
    applyStimulus(mk(1, HEAD, 32'h3));
    applyStimulus(mk(1, TAIL, 32'h3B));
    pkti = '0;
    checkOutput("t3 req first", req, 5'b00001);
    checkOutput("t3 pkto first", pkto, mk(0, HEADTAIL, 32'h10));
    ack = 1'b1;
    step();
    checkOutput("t3 req gap", req, 0);
    checkOutput("t3 credit ht", credit, 2'b01);
    step();
    checkOutput("t3 req vc1", req, 5'b01000);
    checkOutput("t3 vc1 head", pkto, mk(1, HEAD, 32'h3));
    step();
    checkOutput("t3 vc1 tail", pkto, mk(1, TAIL, 32'h3B));
    checkOutput("t3 credit vc1", credit, 2'b10);
    step();
    checkOutput("t3 req gap2", req, 0);
    step();
    checkOutput("t3 req vc0", req, 5'b00010);
    checkOutput("t3 vc0 head", pkto, mk(0, HEAD, 32'h1));
    step();
    checkOutput("t3 vc0 tail", pkto, mk(0, TAIL, 32'h2A));
    step();
    checkOutput("t3 req end", req, 0);
    step();

    $display("[TB] headtail on VC1 with delayed ack");
    ack = 1'b0;
    applyStimulus(mk(1, HEADTAIL, 32'h4));
    pkti = '0;
    checkOutput("t2 req t+1", req, 0);
    step();
    checkOutput("t2 req c1", req, 5'b10000);
    checkOutput("t2 pkto", pkto, mk(1, HEADTAIL, 32'h4));
    step();
    checkOutput("t2 req c2", req, 5'b10000);
    checkOutput("t2 no credit", credit, 0);
    step();
    checkOutput("t2 req c3", req, 5'b10000);
    ack = 1'b1;
    step();
    checkOutput("t2 req done", req, 0);
    checkOutput("t2 credit", credit, 2'b10);
    checkOutput("t2 pkto idle", pkto, 0);
    step();
    checkOutput("t2 credit end", credit, 0);

    $display("[TB] overflow on VC0");
    ack = 1'b0;
    applyStimulus(mk(0, HEAD, 32'h0));
    applyStimulus(mk(0, BODY, 32'h11));
    applyStimulus(mk(0, BODY, 32'h22));
    checkOutput("t4 full 3", full, 2'b00);
    applyStimulus(mk(0, TAIL, 32'h33));
    checkOutput("t4 full 4", full, 2'b01);
    checkOutput("t4 ovf before", err_ovf, 0);
    applyStimulus(mk(0, BODY, 32'h55));
    checkOutput("t4 ovf pulse", err_ovf, 1);
    checkOutput("t4 full held", full, 2'b01);
    applyStimulus(mk(1, HEADTAIL, 32'h3));
    pkti = '0;
    checkOutput("t4 ovf end", err_ovf, 0);
    checkOutput("t4 full vc1 ok", full, 2'b01);
    checkOutput("t4 req", req, 5'b00001);
    checkOutput("t4 head out", pkto, mk(0, HEAD, 32'h0));
    ack = 1'b1;
    step();
    checkOutput("t4 full drain", full, 2'b00);
    checkOutput("t4 body1 out", pkto, mk(0, BODY, 32'h11));
    step();
    checkOutput("t4 body2 out", pkto, mk(0, BODY, 32'h22));
    step();
    checkOutput("t4 tail out", pkto, mk(0, TAIL, 32'h33));
    step();
    checkOutput("t4 req gap", req, 0);
    checkOutput("t4 pkto gap", pkto, 0);
    step();
    checkOutput("t4 req vc1", req, 5'b01000);
    checkOutput("t4 vc1 out", pkto, mk(1, HEADTAIL, 32'h3));
    step();
    checkOutput("t4 req end", req, 0);
    checkOutput("t4 credit vc1", credit, 2'b10);
    step();

    $display("[TB] bad destination dropped");
    ack = 1'b1;
    applyStimulus(mk(0, HEAD, 32'h6));
    applyStimulus(mk(0, BODY, 32'h66));
    checkOutput("t5 err_pkt", err_pkt, 1);
    checkOutput("t5 req drop", req, 0);
    checkOutput("t5 pkto drop", pkto, 0);
    applyStimulus(mk(0, TAIL, 32'h67));
    pkti = '0;
    checkOutput("t5 err_pkt end", err_pkt, 0);
    checkOutput("t5 credit a", credit, 2'b01);
    checkOutput("t5 pkto drop2", pkto, 0);
    step();
    checkOutput("t5 credit b", credit, 2'b01);
    step();
    checkOutput("t5 credit c", credit, 2'b01);
    checkOutput("t5 req still", req, 0);
    step();
    checkOutput("t5 credit end", credit, 0);
    checkOutput("t5 err_pkt quiet", err_pkt, 0);
    applyStimulus(mk(0, HEADTAIL, 32'h2));
    pkti = '0;
    step();
    checkOutput("t5 good req", req, 5'b00100);
    checkOutput("t5 good out", pkto, mk(0, HEADTAIL, 32'h2));
    step();
    checkOutput("t5 good done", req, 0);
    checkOutput("t5 good credit", credit, 2'b01);
    step();

    $display("[TB] reset during transfer");
    ack = 1'b1;
    applyStimulus(mk(1, HEAD, 32'h1));
    applyStimulus(mk(1, BODY, 32'hA1));
    applyStimulus(mk(1, BODY, 32'hA2));
    pkti = '0;
    checkOutput("t6 mid body", pkto, mk(1, BODY, 32'hA1));
    checkOutput("t6 mid req", req, 5'b00010);
    rst = 1'b1;
    #1;
    checkOutput("t6 rst req", req, 0);
    checkOutput("t6 rst pkto", pkto, 0);
    checkOutput("t6 rst full", full, 0);
    checkOutput("t6 rst credit", credit, 0);
    step();
    rst = 1'b0;
    step();
    checkOutput("t6 post req", req, 0);
    checkOutput("t6 post credit", credit, 0);
    checkOutput("t6 post pkto", pkto, 0);
    step();
    checkOutput("t6 post credit2", credit, 0);
    checkOutput("t6 post req2", req, 0);
    applyStimulus(mk(0, HEADTAIL, 32'h4));
    pkti = '0;
    checkOutput("t6 new t+1", req, 0);
    step();
    checkOutput("t6 new req", req, 5'b10000);
    checkOutput("t6 new out", pkto, mk(0, HEADTAIL, 32'h4));
    step();
    checkOutput("t6 new done", req, 0);
    checkOutput("t6 new credit", credit, 2'b01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
